q_mult: RTL and testbench

Sequential signed fixed-point multiplier used as the product stage of the MAC unit. It accepts one operand pair per transaction and computes their product with an iterative shift-add datapath, one multiplier bit per cycle. It rescales the product back to the fixed-point format, saturates it to 32 bits and presents it with a one-cycle valid pulse. The MAC unit adds its latched addend to `product_dout` when `product_dout_vld` is high.

---
 rtl/q_mult.sv | 158 +++++++++++++++
 tb/tb_q_mult.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/q_mult.sv
// Sequential signed fixed-point multiplier: shift-add over N cycles, then
// rescale by Q fractional bits, saturate to 32 bits and present with a vld pulse.
module q_mult #(
    parameter int N = 32,
    parameter int Q = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         input_vld,
    input  logic [N-1:0] multiplicand_din,
    input  logic [N-1:0] multiplier_din,
    output logic [31:0]  product_dout,
    output logic         product_dout_vld,
    output logic         product_end
);

    localparam int CW = $clog2(N) + 1;
    localparam int SW = 2 * N + 1;
    localparam int EW = (SW > 32) ? SW : 33;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2*N-1:0]     mcand_q, mcand_d;
    logic [N-1:0]       mplier_q, mplier_d;
    logic [2*N-1:0]     acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic [31:0]        dout_q, dout_d;
    logic               vld_q, vld_d;
    logic               end_q, end_d;

    logic signed [SW-1:0] mag_s;
    logic signed [SW-1:0] signed_s;
    logic signed [SW-1:0] scaled_s;
    logic signed [EW-1:0] ext_s;

    // The most negative operand maps to 2^(N-1), which still fits N unsigned bits.
    function automatic logic [N-1:0] abs_val(input logic [N-1:0] v);
        logic [N-1:0] r;
        if (v[N-1]) begin
            r = ~v + {{(N-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic [31:0] sat32(input logic signed [EW-1:0] v);
        logic [31:0] r;
        if ((&v[EW-1:31]) || !(|v[EW-1:31])) begin
            r = v[31:0];
        end else if (v[EW-1]) begin
            r = 32'h8000_0000;
        end else begin
            r = 32'h7FFF_FFFF;
        end
        return r;
    endfunction

    // Sign application, floor rescale and sign extension ahead of saturation.
    always_comb begin
        mag_s    = $signed({1'b0, acc_q});
        signed_s = mag_s;
        if (sign_q) begin
            signed_s = -mag_s;
        end else begin
            signed_s = mag_s;
        end
        scaled_s = signed_s >>> Q;
        ext_s    = EW'(scaled_s);
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        dout_d   = dout_q;
        vld_d    = 1'b0;
        end_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (input_vld) begin
                    mcand_d  = {{N{1'b0}}, abs_val(multiplicand_din)};
                    mplier_d = abs_val(multiplier_din);
                    sign_d   = multiplicand_din[N-1] ^ multiplier_din[N-1];
                    acc_d    = {(2*N){1'b0}};
                    cnt_d    = {CW{1'b0}};
                    state_d  = BUSY;
                end else begin
                    state_d  = IDLE;
                end
            end
            BUSY: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end else begin
                    acc_d = acc_q;
                end
                mcand_d  = {mcand_q[2*N-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[N-1:1]};
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = FINISH;
                    end_d   = 1'b1;
                end else begin
                    state_d = BUSY;
                end
            end
            FINISH: begin
                dout_d  = sat32(ext_s);
                vld_d   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= {(2*N){1'b0}};
            mplier_q <= {N{1'b0}};
            acc_q    <= {(2*N){1'b0}};
            cnt_q    <= {CW{1'b0}};
            sign_q   <= 1'b0;
            dout_q   <= 32'h0000_0000;
            vld_q    <= 1'b0;
            end_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            dout_q   <= dout_d;
            vld_q    <= vld_d;
            end_q    <= end_d;
        end
    end

    assign product_dout     = dout_q;
    assign product_dout_vld = vld_q;
    assign product_end      = end_q;

endmodule

// File: tb/tb_q_mult.sv
// Randomized self-checking bench for q_mult against a plain-arithmetic model,
// plus directed cases with hand-computed results and latencies.
module tb_q_mult;

    localparam int N = 32;
    localparam int Q = 16;
    localparam longint MAXV = 64'sh0000_0000_7FFF_FFFF;
    localparam longint MINV = 64'shFFFF_FFFF_8000_0000;

    logic        clk;
    logic        rst_n;
    logic        input_vld;
    logic [31:0] a_s;
    logic [31:0] b_s;
    logic [31:0] product_dout;
    logic        product_dout_vld;
    logic        product_end;

    int checks = 0;
    int errors = 0;

    q_mult #(.N(N), .Q(Q)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .input_vld        (input_vld),
        .multiplicand_din (a_s),
        .multiplier_din   (b_s),
        .product_dout     (product_dout),
        .product_dout_vld (product_dout_vld),
        .product_end      (product_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        p = p >>> Q;
        if (p > MAXV) return 32'h7FFF_FFFF;
        if (p < MINV) return 32'h8000_0000;
        return p[31:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s got=%h exp=%h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Timing model: edge count, accepted transaction and when its outputs appear.
    int          cyc     = 0;
    int          free_at = 0;
    int          e_end   = -1;
    int          e_vld   = -1;
    logic [31:0] pend    = 32'h0;
    logic [31:0] exp_dout = 32'h0;
    logic        started = 1'b0;

    always @(posedge clk) begin
        automatic int ec = cyc + 1;
        cyc     <= ec;
        started <= 1'b1;
        if (!rst_n) begin
            free_at  <= 0;
            e_end    <= -1;
            e_vld    <= -1;
            exp_dout <= 32'h0;
        end else begin
            if (ec == e_vld) exp_dout <= pend;
            if (ec >= free_at && input_vld) begin
                pend    <= ref_mult(a_s, b_s);
                e_end   <= ec + N;
                e_vld   <= ec + N + 1;
                free_at <= ec + N + 2;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("cyc_end",  {31'b0, product_end},      {31'b0, cyc == e_end});
            chk("cyc_vld",  {31'b0, product_dout_vld}, {31'b0, cyc == e_vld});
            chk("cyc_dout", product_dout, exp_dout);
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string nm);
        int e0, lat_end, lat_vld;
        logic [31:0] res;
        lat_end = -1;
        lat_vld = -1;
        res = 32'hDEAD_BEEF;
        @(negedge clk);
        a_s = a; b_s = b; input_vld = 1'b1;
        @(posedge clk);
        #1 e0 = cyc;
        for (int i = 0; i < 60 && lat_vld < 0; i++) begin
            @(negedge clk);
            input_vld = 1'b0;
            a_s = $urandom; b_s = $urandom;
            if (product_end && lat_end < 0) lat_end = cyc - e0;
            if (product_dout_vld) begin
                lat_vld = cyc - e0;
                res = product_dout;
            end
        end
        chk({nm, "_end_lat"}, 32'(lat_end), 32'd32);
        chk({nm, "_vld_lat"}, 32'(lat_vld), 32'd33);
        chk({nm, "_val"}, res, exp);
    endtask

    function automatic logic [31:0] gen();
        logic [19:0] t20;
        logic [24:0] t25;
        logic [31:0] ext[5];
        ext[0] = 32'h8000_0000; ext[1] = 32'h7FFF_FFFF; ext[2] = 32'h0;
        ext[3] = 32'h1;         ext[4] = 32'hFFFF_FFFF;
        t20 = 20'($urandom);
        t25 = 25'($urandom);
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return {{12{t20[19]}}, t20};
            2: return ext[$urandom_range(0, 4)];
            default: return {{7{t25[24]}}, t25};
        endcase
    endfunction

    initial begin
        int e0, c, nv, v1, v2;
        logic [31:0] r1, r2;
        rst_n = 1'b0; input_vld = 1'b0; a_s = 32'h0; b_s = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_dout", product_dout, 32'h0);
        chk("rst_vld", {31'b0, product_dout_vld}, 32'h0);
        chk("rst_end", {31'b0, product_end}, 32'h0);
        rst_n = 1'b1;

        run_op(32'h0001_8000, 32'h0002_0000, 32'h0003_0000, "p15x2");
        run_op(32'hFFFE_8000, 32'h0002_0000, 32'hFFFD_0000, "m15x2");
        run_op(32'hFFFE_8000, 32'hFFFE_0000, 32'h0003_0000, "m15xm2");
        run_op(32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "floor");
        run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, "sat_pp");
        run_op(32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, "sat_nn");
        run_op(32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, "sat_np");
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, "zero");

        // Busy rejection followed by a back-to-back strobe one cycle after vld.
        nv = 0; v1 = -1; v2 = -1; r1 = 32'h0; r2 = 32'h0;
        @(negedge clk);
        a_s = 32'h0001_0000; b_s = 32'h0003_0000; input_vld = 1'b1;
        @(posedge clk);
        #1 e0 = cyc;
        for (int i = 0; i < 90; i++) begin
            @(negedge clk);
            c = cyc - e0;
            input_vld = (c == 4) || (c == 33);
            if (c == 4)  begin a_s = 32'h0005_0000; b_s = 32'h0005_0000; end
            if (c == 33) begin a_s = 32'h0002_0000; b_s = 32'h0002_8000; end
            if (product_dout_vld) begin
                nv++;
                if (nv == 1) begin r1 = product_dout; v1 = c; end
                else if (nv == 2) begin r2 = product_dout; v2 = c; end
            end
        end
        chk("busy_nres", 32'(nv), 32'd2);
        chk("busy_r1", r1, 32'h0003_0000);
        chk("busy_v1", 32'(v1), 32'd33);
        chk("b2b_r2", r2, 32'h0005_0000);
        chk("b2b_v2", 32'(v2), 32'd67);

        // Reset at E10 aborts the transaction.
        nv = 0;
        @(negedge clk);
        a_s = 32'h0001_8000; b_s = 32'h0002_0000; input_vld = 1'b1;
        @(posedge clk);
        #1 e0 = cyc;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            c = cyc - e0;
            input_vld = 1'b0;
            rst_n = (c != 9);
            if (c == 10) begin
                chk("mrst_dout", product_dout, 32'h0);
                chk("mrst_vld", {31'b0, product_dout_vld}, 32'h0);
                chk("mrst_end", {31'b0, product_end}, 32'h0);
            end
            if (product_dout_vld || product_end) nv++;
        end
        rst_n = 1'b1;
        chk("mrst_novld", 32'(nv), 32'd0);
        run_op(32'h0003_0000, 32'hFFFF_8000, 32'hFFFE_8000, "post_rst");

        // Random traffic, including strobes and data changes while busy.
        for (int i = 0; i < 7000; i++) begin
            @(negedge clk);
            input_vld = ($urandom_range(0, 2) == 0);
            a_s = gen();
            b_s = gen();
            rst_n = ($urandom_range(0, 599) != 0);
        end
        @(negedge clk);
        rst_n = 1'b1; input_vld = 1'b0;
        repeat (40) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
